// File: rtl/seq_divider.sv
// Sequential restoring divider (signed/unsigned); result WIDTH+1 cycles after accept, 1 cycle for divisor==0.
// Start is only taken in IDLE; requests while busy are dropped.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic             q_neg;
  logic             r_neg;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             unused_bits;

  // -2^(WIDTH-1) negates to itself, which read as unsigned is the correct magnitude.
  always_comb begin
    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -dividend : dividend;
    dvs_mag = dvs_neg ? -divisor : divisor;
  end

  always_comb begin
    rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs};
    if (diff[WIDTH+1]) begin
      rem_nxt = rem_sh;
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = diff[WIDTH:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

  // The partial remainder is always below the divisor after a step, so its top bit never reaches the outputs.
  assign unused_bits = ^{rem[WIDTH], rem_nxt[WIDTH]};

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      quo         <= '0;
      dvs         <= '0;
      rem         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            quo   <= dvd_mag;
            dvs   <= dvs_mag;
            rem   <= '0;
            q_neg <= dvd_neg ^ dvs_neg;
            r_neg <= dvd_neg;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= FINISH;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          quo <= quo_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient    <= q_neg ? -quo_nxt : quo_nxt;
            remainder   <= r_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
            state       <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): reference model feeds a scoreboard queue.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .is_signed(is_signed),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t   e;
    longint x, y, qq, rr;
    if (b == 32'd0) begin
      e.q = '1;
      e.r = a;
      e.z = 1'b1;
      return e;
    end
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    qq = x / y;
    rr = x % y;
    e.q = qq[31:0];
    e.r = rr[31:0];
    e.z = 1'b0;
    return e;
  endfunction

  // Called #1 after a rising edge: start is seen by the next edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    sb.push_back(model(a, b, s));
  endtask

  // lat = edges from the issue point until done is seen (-1 on timeout); bcnt = samples with busy high.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
      start = 1'b0;
      if (done) return;
    end
    lat = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset quotient: got %h expected 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset remainder: got %h expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset div_by_zero: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int   lat, bc;
    exp_t e;
    issue(32'd100, 32'd7, 1'b0);
    wait_done(lat, bc);
    e = sb.pop_front();
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL unsigned latency: got %0d expected 33", lat); end
    n_checks++; if (bc != 33) begin n_fail++; $display("FAIL unsigned busy cycles: got %0d expected 33", bc); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL unsigned quotient: got %h expected %h", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL unsigned remainder: got %h expected %h", remainder, e.r); end
    n_checks++; if (quotient !== 32'd14) begin n_fail++; $display("FAIL unsigned quotient literal: got %h expected 0000000e", quotient); end
    @(posedge clk);
    #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL unsigned done width: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL unsigned busy after: got %b expected 0", busy); end
  endtask

  task automatic test_table(input string nm, input int n, input logic [31:0] av[8],
                            input logic [31:0] bv[8], input logic sv[8]);
    int   lat, bc, want;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      issue(av[i], bv[i], sv[i]);
      wait_done(lat, bc);
      e = sb.pop_front();
      want = (bv[i] == 32'd0) ? 1 : 33;
      n_checks++; if (lat != want) begin n_fail++; $display("FAIL %s[%0d] latency: got %0d expected %0d", nm, i, lat, want); end
      n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL %s[%0d] quotient: got %h expected %h", nm, i, quotient, e.q); end
      n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL %s[%0d] remainder: got %h expected %h", nm, i, remainder, e.r); end
      n_checks++; if (div_by_zero !== e.z) begin n_fail++; $display("FAIL %s[%0d] div_by_zero: got %b expected %b", nm, i, div_by_zero, e.z); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_signed;
    logic [31:0] av[8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'hFFFFFF9C, 32'hFFFFFFFF, 0, 0, 0};
    logic [31:0] bv[8] = '{32'd2, 32'd2, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd1, 0, 0, 0};
    logic        sv[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0};
    test_table("signed", 5, av, bv, sv);
    issue(32'hFFFFFFF9, 32'd2, 1'b1);
    begin
      int lat, bc;
      exp_t e;
      wait_done(lat, bc);
      e = sb.pop_front();
      n_checks++; if (quotient !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL signed literal quotient: got %h expected fffffffd", quotient); end
      n_checks++; if (remainder !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL signed literal remainder: got %h expected ffffffff", remainder); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_overflow;
    logic [31:0] av[8] = '{32'h80000000, 32'h80000000, 0, 0, 0, 0, 0, 0};
    logic [31:0] bv[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0};
    logic        sv[8] = '{1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    test_table("overflow", 2, av, bv, sv);
  endtask

  task automatic test_div_zero;
    int   lat, bc;
    exp_t e;
    issue(32'h12345678, 32'd0, 1'b0);
    wait_done(lat, bc);
    e = sb.pop_front();
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div0 latency: got %0d expected 1", lat); end
    n_checks++; if (bc != 1) begin n_fail++; $display("FAIL div0 busy cycles: got %0d expected 1", bc); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL div0 quotient: got %h expected %h", quotient, e.q); end
    n_checks++; if (remainder !== 32'h12345678) begin n_fail++; $display("FAIL div0 remainder: got %h expected 12345678", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0 flag: got %b expected 1", div_by_zero); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div0 hold quotient: got %h expected ffffffff", quotient); end
    n_checks++; if (remainder !== 32'h12345678) begin n_fail++; $display("FAIL div0 hold remainder: got %h expected 12345678", remainder); end
    n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0 hold flag: got %b expected 1", div_by_zero); end
    issue(32'hFFFFFF00, 32'd0, 1'b1);
    wait_done(lat, bc);
    e = sb.pop_front();
    n_checks++; if (lat != 1) begin n_fail++; $display("FAIL div0s latency: got %0d expected 1", lat); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL div0s remainder: got %h expected %h", remainder, e.r); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_busy;
    int          lat, bc;
    exp_t        e;
    logic [31:0] prev_q, prev_r;
    logic        prev_z;
    prev_q = quotient;
    prev_r = remainder;
    prev_z = div_by_zero;
    issue(32'd1000, 32'd10, 1'b0);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 || i == 12) start = 1'b0;
      if (i == 11) begin
        n_checks++; if (quotient !== prev_q) begin n_fail++; $display("FAIL ignore hold quotient: got %h expected %h", quotient, prev_q); end
        n_checks++; if (remainder !== prev_r) begin n_fail++; $display("FAIL ignore hold remainder: got %h expected %h", remainder, prev_r); end
        n_checks++; if (div_by_zero !== prev_z) begin n_fail++; $display("FAIL ignore hold flag: got %b expected %b", div_by_zero, prev_z); end
        dividend  = 32'd5;
        divisor   = 32'd0;
        is_signed = 1'b1;
        start     = 1'b1;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    e = sb.pop_front();
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL ignore latency: got %0d expected 33", lat); end
    n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL ignore quotient: got %h expected %h", quotient, e.q); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL ignore remainder: got %h expected %h", remainder, e.r); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ignore flag: got %b expected 0", div_by_zero); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int   lat, bc;
    exp_t e;
    logic [31:0] av[3] = '{32'd81, 32'hFFFFFFEC, 32'hDEADBEEF};
    logic [31:0] bv[3] = '{32'd9, 32'd3, 32'h00001234};
    logic        sv[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      issue(av[i], bv[i], sv[i]);
      wait_done(lat, bc);
      e = sb.pop_front();
      n_checks++; if (lat != 33) begin n_fail++; $display("FAIL b2b[%0d] latency: got %0d expected 33", i, lat); end
      n_checks++; if (quotient !== e.q) begin n_fail++; $display("FAIL b2b[%0d] quotient: got %h expected %h", i, quotient, e.q); end
      n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL b2b[%0d] remainder: got %h expected %h", i, remainder, e.r); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_calc;
    int   lat, bc;
    exp_t e;
    issue(32'd1000, 32'd3, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    void'(sb.pop_front());
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst done: got %b expected 0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL midrst quotient: got %h expected 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL midrst remainder: got %h expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midrst flag: got %b expected 0", div_by_zero); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(32'd50, 32'd5, 1'b0);
    wait_done(lat, bc);
    e = sb.pop_front();
    n_checks++; if (lat != 33) begin n_fail++; $display("FAIL midrst new latency: got %0d expected 33", lat); end
    n_checks++; if (quotient !== 32'd10) begin n_fail++; $display("FAIL midrst new quotient: got %h expected 0000000a", quotient); end
    n_checks++; if (remainder !== e.r) begin n_fail++; $display("FAIL midrst new remainder: got %h expected %h", remainder, e.r); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [31:0] av[8];
    logic [31:0] bv[8];
    logic        sv[8];
    for (int i = 0; i < 8; i++) begin
      av[i] = $urandom;
      bv[i] = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      if (i == 3) bv[i] = 32'd0;
      sv[i] = 1'($urandom_range(0, 1));
    end
    test_table("random", 8, av, bv, sv);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
